ad_dac_tx: RTL and testbench
============================

// Module: ad_dac_tx
// PURPOSE
// - Transmit-side counterpart of the AD9226 ADC capture path: drives a parallel offset-binary DAC
//   (AD9708/DAC902 class) from an AXI-Stream of signed samples.
// - Buffers samples in a small FIFO, generates the DAC sample clock by dividing clk, and converts
//   two's-complement to offset binary. Data changes on the dac_clk falling edge, so the DAC latches on the rising edge.
// - Sits between the DSP/DMA stream and the DAC pins; configured through one 32-bit config word.
// PARAMETERS
// - DAC_DATA_WIDTH   12  sample width in bits, both stream side and pin side
// - FIFO_DEPTH_LOG2  4   log2 of FIFO depth (16 entries)
// PORTS
// - clk            in   1                system clock; all logic on posedge
// - rst_n          in   1                asynchronous, active-low reset
// - s_axis_tdata   in   DAC_DATA_WIDTH   signed (two's-complement) sample
// - s_axis_tvalid  in   1                stream valid
// - s_axis_tready  out  1                stream ready
// - configDac      in   32               [31] enable, [30] underrun mode, [29] underrun clear, [28] ramp select, [7:0] DIV
// - dac_clk        out  1                DAC sample clock
// - dac_data       out  DAC_DATA_WIDTH   offset-binary DAC code
// - sample_strobe  out  1                1-cycle pulse on each dac_data update
// - underrun       out  1                sticky underrun flag
// - underrun_cnt   out  16               saturating underrun counter
// BEHAVIOUR
// - Reset values: dac_clk=0, dac_data=MID=1<<(W-1) (0x800 for W=12), s_axis_tready=0, sample_strobe=0,
//   underrun=0, underrun_cnt=0. FIFO is empty; FSM is in IDLE. Reset mid-operation aborts immediately.
// - Conversion: dac_data = tdata with the MSB inverted. Examples: -2048 -> 0x000, 0 -> 0x800, 2047 -> 0xFFF.
// - FIFO handshake:
//   - s_axis_tready = enable & !full, registered.
//   - Push when tvalid & tready. Pop only at a sample update.
//   - Simultaneous push and pop are both honoured; count is unchanged.
//   - Order is preserved; no sample is dropped or duplicated.
// - FSM states IDLE, LOW, HIGH. Phase length is DIV+1 clk cycles, so the dac_clk period is 2*(DIV+1).
//   DIV is sampled at the start of each phase.
//   - IDLE: dac_clk=0, dac_data=MID. Leaves for LOW when enable=1 and the FIFO is non-empty (prefill of one sample).
//   - Entering LOW (dac_clk falls): pop, update dac_data, pulse sample_strobe in the same cycle.
//     Latency is 1 clk from the enable&!empty condition to dac_data valid.
//   - LOW -> HIGH after DIV+1 cycles; dac_clk=1.
//   - HIGH -> LOW after DIV+1 cycles (next update).
//   - HIGH -> IDLE instead, if enable=0 at the end of HIGH. On entering IDLE the FIFO is flushed and dac_data=MID.
// - Underrun: FIFO empty at an update instant (not the IDLE exit).
//   - Sets underrun; underrun_cnt++ (saturates at 0xFFFF); sample_strobe still pulses.
//   - dac_data holds its last value (mode=0) or goes to MID (mode=1).
//   - configDac[29]=1 clears both underrun and underrun_cnt; clear wins over a same-cycle set.
// CONFIGURATION
// - Macro DAC_RAMP_TEST_EN:
//   - Defined: configDac[28]=1 replaces the FIFO source with an internal W-bit offset-binary ramp.
//     The ramp starts at 0 on IDLE exit, increments by 1 per update, and wraps 0xFFF -> 0x000.
//     While selected: s_axis_tready=0, no pops, no underruns; the IDLE exit needs no prefill.
//   - Not defined: configDac[28] is ignored and no ramp logic is built.
// TESTING
// - Reset: assert rst_n low mid-HIGH with DIV=2 -> dac_clk=0, dac_data=0x800, tready=0, underrun=0, cnt=0 asynchronously.
// - DIV=0, enable, stream -2048,0,2047 -> dac_data 0x000,0x800,0xFFF on successive dac_clk falls;
//   period 2 clk; one strobe per sample.
// - DIV=3 -> dac_clk 4 clk high / 4 low; dac_data changes only in the falling-edge cycle; DIV 3->1 mid-phase takes effect next phase.
// - Push 100 only, mode=0 -> dac_data holds 0x864, underrun=1, cnt increments each period.
//   Mode=1 -> 0x800. Pulse [29] -> flag=0, cnt=0.
// - DIV=255, push 20 back-to-back -> tready low once 16 are held; all 20 emerge in order after being accepted.
// - Disable mid-stream -> current HIGH phase completes, FSM to IDLE, dac_data=0x800, FIFO empty, tready=0.

Source files
------------

// File: rtl/ad_dac_tx.sv
// rtl/ad_dac_tx.sv - AXI-Stream sample FIFO driving a parallel offset-binary DAC with divided sample clock
// Optional build macro: DAC_RAMP_TEST_EN (internal offset-binary ramp source selected by configDac[28])
module ad_dac_tx #(
  parameter int DAC_DATA_WIDTH  = 12,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DAC_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [31:0]               configDac,
  output logic                      dac_clk,
  output logic [DAC_DATA_WIDTH-1:0] dac_data,
  output logic                      sample_strobe,
  output logic                      underrun,
  output logic [15:0]               underrun_cnt
);

  localparam int W     = DAC_DATA_WIDTH;
  localparam int F     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << F;

  localparam logic [W-1:0] MID     = {1'b1, {(W-1){1'b0}}};
  localparam logic [F-1:0] PTR_ONE = {{(F-1){1'b0}}, 1'b1};
  localparam logic [F:0]   CNT_ONE = {{F{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Configuration fields
  logic       w_enable;
  logic       w_mode;
  logic       w_clear;
  logic [7:0] w_div_cfg;
  logic       w_ramp_sel;

  assign w_enable  = configDac[31];
  assign w_mode    = configDac[30];
  assign w_clear   = configDac[29];
  assign w_div_cfg = configDac[7:0];

  // FIFO storage and bookkeeping
  logic [W-1:0] r_mem [DEPTH];
  logic [F-1:0] r_wr_ptr;
  logic [F-1:0] r_rd_ptr;
  logic [F:0]   r_count;
  logic [F:0]   w_count_nxt;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic [W-1:0] w_head;
  logic [W-1:0] w_head_ob;

  // Phase timing
  logic [7:0] r_div;
  logic [7:0] r_phase_cnt;
  logic       w_phase_end;
  logic       w_phase_start;

  // FSM events
  logic w_update;
  logic w_go_idle;
  logic w_exit_idle;
  logic w_underrun_evt;

  // Output registers
  logic         r_tready;
  logic         r_dac_clk;
  logic [W-1:0] r_dac_data;
  logic         r_strobe;
  logic         r_underrun;
  logic [15:0]  r_underrun_cnt;

`ifdef DAC_RAMP_TEST_EN
  logic [W-1:0] r_ramp;
  localparam logic [W-1:0] RAMP_ONE = {{(W-1){1'b0}}, 1'b1};
  assign w_ramp_sel = configDac[28];
  logic w_unused;
  assign w_unused = &{1'b0, configDac[27:8]};
`else
  assign w_ramp_sel = 1'b0;
  logic w_unused;
  assign w_unused = &{1'b0, configDac[28:8]};
`endif

  assign w_empty     = (r_count == '0);
  assign w_phase_end = (r_phase_cnt == r_div);
  assign w_head      = r_mem[r_rd_ptr];
  // Two's complement to offset binary is an MSB flip
  assign w_head_ob   = {~w_head[W-1], w_head[W-2:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and the update / idle-entry events it implies
  always_comb begin
    w_state_nxt   = r_state;
    w_update      = 1'b0;
    w_go_idle     = 1'b0;
    w_phase_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enable && (!w_empty || w_ramp_sel)) begin
          w_state_nxt   = LOW;
          w_update      = 1'b1;
          w_phase_start = 1'b1;
        end
      end
      LOW: begin
        if (w_phase_end) begin
          w_state_nxt   = HIGH;
          w_phase_start = 1'b1;
        end
      end
      HIGH: begin
        if (w_phase_end) begin
          w_phase_start = 1'b1;
          if (w_enable) begin
            w_state_nxt = LOW;
            w_update    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_go_idle   = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_exit_idle    = (r_state == IDLE) && w_update;
  assign w_push         = s_axis_tvalid && r_tready;
  assign w_pop          = w_update && !w_ramp_sel && !w_empty;
  // The IDLE exit always has data (or the ramp), so only steady-state updates can underrun
  assign w_underrun_evt = w_update && !w_ramp_sel && w_empty;

  // FIFO occupancy after this cycle's push/pop/flush
  always_comb begin
    w_count_nxt = r_count;
    if (w_go_idle)              w_count_nxt = '0;
    else if (w_push && !w_pop)  w_count_nxt = r_count + CNT_ONE;
    else if (!w_push && w_pop)  w_count_nxt = r_count - CNT_ONE;
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_axis_tdata;
  end

  // FIFO pointers and count; entering IDLE flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_go_idle) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
    end
  end

  // Ready is registered from the next occupancy so a full FIFO never accepts a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tready <= 1'b0;
    else        r_tready <= w_enable && !w_ramp_sel && !w_count_nxt[F];
  end

  // Phase counter; DIV is captured at the start of every phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_phase_cnt <= '0;
    end else if (w_phase_start) begin
      r_div       <= w_div_cfg;
      r_phase_cnt <= '0;
    end else if (r_state != IDLE) begin
      r_phase_cnt <= r_phase_cnt + 8'd1;
    end
  end

  // DAC clock follows the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dac_clk <= 1'b0;
    else        r_dac_clk <= (w_state_nxt == HIGH);
  end

  // DAC data and strobe change together on the falling dac_clk edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dac_data <= MID;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= w_update;
      if (w_go_idle) begin
        r_dac_data <= MID;
      end else if (w_update) begin
        if (w_ramp_sel) begin
`ifdef DAC_RAMP_TEST_EN
          r_dac_data <= w_exit_idle ? '0 : r_ramp;
`endif
        end else if (!w_empty) begin
          r_dac_data <= w_head_ob;
        end else if (w_mode) begin
          r_dac_data <= MID;
        end
      end
    end
  end

`ifdef DAC_RAMP_TEST_EN
  // Ramp holds the code for the next update; restarts from zero on every IDLE exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp <= '0;
    end else if (w_go_idle) begin
      r_ramp <= '0;
    end else if (w_update && w_ramp_sel) begin
      r_ramp <= w_exit_idle ? RAMP_ONE : r_ramp + RAMP_ONE;
    end
  end
`endif

  // Sticky underrun flag and saturating counter; clear beats a same-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (w_clear) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (w_underrun_evt) begin
      r_underrun <= 1'b1;
      if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign s_axis_tready = r_tready;
  assign dac_clk       = r_dac_clk;
  assign dac_data      = r_dac_data;
  assign sample_strobe = r_strobe;
  assign underrun      = r_underrun;
  assign underrun_cnt  = r_underrun_cnt;

endmodule

// File: tb/tb_ad_dac_tx.sv
// tb/tb_ad_dac_tx.sv - self-checking bench for ad_dac_tx against a queue-based sample model
module tb_ad_dac_tx;

  localparam logic [11:0] MID = 12'h800;

  logic        clk;
  logic        rst_n;
  logic [11:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] configDac;
  logic        dac_clk;
  logic [11:0] dac_data;
  logic        sample_strobe;
  logic        underrun;
  logic [15:0] underrun_cnt;

  ad_dac_tx #(.DAC_DATA_WIDTH(12), .FIFO_DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .configDac     (configDac),
    .dac_clk       (dac_clk),
    .dac_data      (dac_data),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .underrun_cnt  (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_q [$];
  logic [11:0] last_code;
  int          m_ucnt;
  bit          m_uflag;
  logic        prev_clk;
  logic [11:0] prev_data;
  bit          ph_active;
  int          ph_len;
  int          ph_div;
  int          n_accept;
  int          n_strobe;

  function automatic logic [11:0] to_ob(logic [11:0] s);
    int v;
    v = $signed(s);
    return 12'(v + 2048);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input bit en, input bit mode, input bit clr, input logic [7:0] div);
    configDac = {en, mode, clr, 1'b0, 20'h00000, div};
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_code = MID;
    m_ucnt    = 0;
    m_uflag   = 0;
    prev_clk  = 1'b0;
    prev_data = MID;
    ph_active = 0;
    ph_len    = 0;
    ph_div    = 0;
  endtask

  // One clock: inputs captured before the edge, outputs checked 1 time unit after it
  task automatic step();
    bit          push, clr, mode_b, en_b, flush;
    logic [11:0] d;
    logic [7:0]  div_b;
    logic [11:0] e;
    push   = s_axis_tvalid && s_axis_tready;
    d      = s_axis_tdata;
    en_b   = configDac[31];
    mode_b = configDac[30];
    clr    = configDac[29];
    div_b  = configDac[7:0];
    @(posedge clk);
    #1;
    flush = prev_clk && !dac_clk && !sample_strobe;
    if (sample_strobe) begin
      n_strobe++;
      check("strobe_on_fall", 32'(dac_clk), 32'(0));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = mode_b ? MID : last_code;
        m_uflag = 1;
        if (m_ucnt < 65535) m_ucnt++;
      end
      last_code = e;
      if (clr) begin m_uflag = 0; m_ucnt = 0; end
      check("dac_data", 32'(dac_data), 32'(e));
      check("underrun", 32'(underrun), 32'(m_uflag));
      check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
    end else if (clr) begin
      m_uflag = 0;
      m_ucnt  = 0;
    end
    if (push) begin
      exp_q.push_back(to_ob(d));
      n_accept++;
    end
    if (flush) begin
      exp_q.delete();
      last_code = MID;
      check("idle_mid", 32'(dac_data), 32'(MID));
    end
    if (dac_data !== prev_data)
      check("change_on_update", 32'(sample_strobe || flush), 32'(1));
    if ((dac_clk !== prev_clk) || sample_strobe) begin
      if (ph_active) check("phase_len", 32'(ph_len), 32'(ph_div + 1));
      ph_active = sample_strobe || dac_clk;
      ph_len    = 1;
      ph_div    = int'(div_b);
    end else begin
      ph_len++;
    end
    check("tready", 32'(s_axis_tready), 32'(en_b && (exp_q.size() < 16)));
    prev_clk  = dac_clk;
    prev_data = dac_data;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_one(input logic [11:0] d);
    bit acc;
    int t;
    t = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    forever begin
      acc = s_axis_tvalid && s_axis_tready;
      step();
      if (acc) break;
      t++;
      if (t > 2000) begin
        check("push_timeout_tready", 32'(s_axis_tready), 32'(1));
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_high();
    for (int i = 0; i < 2000 && dac_clk !== 1'b1; i++) step();
    check("wait_dac_clk_high", 32'(dac_clk), 32'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_dac_clk", 32'(dac_clk), 32'(0));
    check("rst_dac_data", 32'(dac_data), 32'(MID));
    check("rst_tready", 32'(s_axis_tready), 32'(0));
    check("rst_strobe", 32'(sample_strobe), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int saved;
    bit saw_full;
    rst_n         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    n_accept      = 0;
    n_strobe      = 0;
    set_cfg(0, 0, 0, 8'd0);
    model_reset();
    #3;
    do_reset();

    // DIV=0: -2048, 0, 2047 then underrun holding the last code
    set_cfg(1, 0, 0, 8'd0);
    push_one(12'h800);
    push_one(12'h000);
    push_one(12'h7FF);
    run(12);
    set_cfg(0, 0, 0, 8'd0);
    run(6);
    check("idle_dac_clk", 32'(dac_clk), 32'(0));
    check("idle_data", 32'(dac_data), 32'(MID));
    saved = n_strobe;
    set_cfg(1, 0, 1, 8'd0);
    run(6);
    check("no_start_when_empty", 32'(n_strobe), 32'(saved));
    set_cfg(0, 0, 0, 8'd0);
    run(2);

    // DIV=3 with random samples, then DIV 3->1 mid-phase
    set_cfg(1, 0, 0, 8'd3);
    for (int i = 0; i < 8; i++) begin
      push_one(12'($urandom));
      run(int'($urandom_range(0, 3)));
    end
    wait_high();
    run(1);
    set_cfg(1, 0, 0, 8'd1);
    run(40);
    set_cfg(0, 0, 0, 8'd1);
    run(10);

    // Underrun: hold (mode 0), MID (mode 1), clear
    set_cfg(1, 0, 0, 8'd1);
    push_one(12'd100);
    run(20);
    check("ur_hold_data", 32'(dac_data), 32'(12'h864));
    check("ur_flag_set", 32'(underrun), 32'(1));
    set_cfg(1, 1, 0, 8'd1);
    run(10);
    check("ur_mode1_mid", 32'(dac_data), 32'(MID));
    set_cfg(1, 1, 1, 8'd1);
    step();
    check("ur_clear_flag", 32'(underrun), 32'(0));
    check("ur_clear_cnt", 32'(underrun_cnt), 32'(0));
    set_cfg(0, 1, 0, 8'd1);
    run(10);

    // DIV=255: 20 back-to-back pushes, FIFO fills, all emerge in order
    set_cfg(1, 0, 0, 8'd255);
    n_accept = 0;
    saw_full = 0;
    saved    = n_strobe;
    for (int i = 0; i < 20; i++) begin
      push_one(12'($urandom));
      if (!s_axis_tready && !saw_full) begin
        saw_full = 1;
        check("full_after_17_accepted", 32'(n_accept), 32'(17));
      end
    end
    check("tready_dropped", 32'(saw_full), 32'(1));
    for (int i = 0; i < 12000 && (n_strobe - saved) < 20; i++) step();
    check("all_20_emerged", 32'(n_strobe - saved), 32'(20));
    set_cfg(0, 0, 0, 8'd255);
    run(600);

    // Disable mid-stream during HIGH with DIV=2
    set_cfg(1, 0, 0, 8'd2);
    for (int i = 0; i < 5; i++) push_one(12'($urandom));
    wait_high();
    set_cfg(0, 0, 0, 8'd2);
    run(8);
    check("dis_dac_clk", 32'(dac_clk), 32'(0));
    check("dis_data", 32'(dac_data), 32'(MID));
    check("dis_tready", 32'(s_axis_tready), 32'(0));
    saved = n_strobe;
    set_cfg(1, 0, 0, 8'd2);
    run(6);
    check("dis_fifo_flushed", 32'(n_strobe), 32'(saved));

    // Asynchronous reset in the middle of a HIGH phase
    for (int i = 0; i < 3; i++) push_one(12'($urandom));
    wait_high();
    step();
    do_reset();
    set_cfg(1, 0, 0, 8'd0);
    push_one(12'($urandom));
    run(4);
    set_cfg(0, 0, 0, 8'd0);
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
